// File: rtl/small_fifo_pkt_reader_if.sv
// Downstream NetFPGA-style packet interface: data/ctrl word with a write strobe
// and a ready from the consumer.
interface small_fifo_pkt_reader_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] out_data;
    logic [CTRL_WIDTH-1:0] out_ctrl;
    logic                  out_wr;
    logic                  out_rdy;

    modport master (
        output out_data,
        output out_ctrl,
        output out_wr,
        input  out_rdy
    );

    modport slave (
        input  out_data,
        input  out_ctrl,
        input  out_wr,
        output out_rdy
    );
endinterface

// File: rtl/small_fifo_pkt_reader.sv
// Drains a registered-read small_fifo through a 2-entry skid buffer and frames
// packets onto the downstream interface, with counters and a sticky framing error.
module small_fifo_pkt_reader #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned CTRL_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [CTRL_WIDTH+DATA_WIDTH-1:0] fifo_dout,
    input  logic                             fifo_empty,
    output logic                             fifo_rd_en,
    small_fifo_pkt_reader_if.master          out,
    input  logic                             pkt_en,
    output logic [CNT_WIDTH-1:0]             word_count,
    output logic [CNT_WIDTH-1:0]             pkt_count,
    output logic                             err_no_hdr
);
    localparam int unsigned WORD_WIDTH = CTRL_WIDTH + DATA_WIDTH;

    typedef enum logic [0:0] {S_HDR, S_BODY} state_t;

    state_t                state;
    logic [WORD_WIDTH-1:0] buf_mem [2];
    logic [WORD_WIDTH-1:0] last_word;
    logic [WORD_WIDTH-1:0] head_word;
    logic                  rd_ptr;
    logic                  wr_ptr;
    logic                  pend;
    logic                  head_is_first;
    logic [1:0]            occ;
    logic [2:0]            fill;
    logic                  hold;

    // With the buffer empty the output keeps showing the last word sent.
    assign head_word    = (occ != 2'd0) ? buf_mem[rd_ptr] : last_word;
    assign out.out_ctrl = head_word[WORD_WIDTH-1 -: CTRL_WIDTH];
    assign out.out_data = head_word[DATA_WIDTH-1:0];

    assign hold       = (state == S_HDR) && head_is_first && !pkt_en;
    assign out.out_wr = !reset && (occ != 2'd0) && out.out_rdy && !hold;

    // Next-cycle occupancy counting the read already in flight.
    assign fill       = {1'b0, occ} + {2'b00, pend} - {2'b00, out.out_wr};
    assign fifo_rd_en = !reset && !fifo_empty && (fill < 3'd2);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_HDR;
            head_is_first <= 1'b1;
            pend          <= 1'b0;
            occ           <= 2'd0;
            rd_ptr        <= 1'b0;
            wr_ptr        <= 1'b0;
            buf_mem[0]    <= '0;
            buf_mem[1]    <= '0;
            last_word     <= '0;
            word_count    <= '0;
            pkt_count     <= '0;
            err_no_hdr    <= 1'b0;
        end else begin
            pend <= fifo_rd_en;
            occ  <= fill[1:0];
            if (pend) begin
                buf_mem[wr_ptr] <= fifo_dout;
                wr_ptr          <= !wr_ptr;
            end
            if (out.out_wr) begin
                rd_ptr     <= !rd_ptr;
                last_word  <= head_word;
                word_count <= word_count + CNT_WIDTH'(1);
                case (state)
                    S_HDR: begin
                        head_is_first <= 1'b0;
                        if (out.out_ctrl == '0) begin
                            state <= S_BODY;
                            if (head_is_first) begin
                                err_no_hdr <= 1'b1;
                            end
                        end
                    end
                    S_BODY: begin
                        if (out.out_ctrl != '0) begin
                            state         <= S_HDR;
                            head_is_first <= 1'b1;
                            pkt_count     <= pkt_count + CNT_WIDTH'(1);
                        end
                    end
                    default: state <= S_HDR;
                endcase
            end
        end
    end
endmodule
